// File: rtl/bck_pkg.sv
// Shared status codes and handshake state encoding for the backward-extension
// pipeline stages.
package bck_pkg;

  localparam int STAT_W = 6;

  typedef enum logic [STAT_W-1:0] {
    BUBBLE  = 6'd0,
    BCK_INI = 6'd1,
    BCK_RUN = 6'd2
  } status_e;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/bck_ext_stage_p_if.sv
// Stage bus: upstream bundle, downstream bundle, mem/curr store ports and
// overflow flag. The master drives the in_* side, the slave is the stage.
interface bck_ext_stage_p_if #(
  parameter int IDX_W  = 64,
  parameter int ADDR_W = 7,
  parameter int RN_W   = 8,
  parameter int STAT_W = bck_pkg::STAT_W
);

  logic                  in_valid;
  logic                  in_ready;
  logic [STAT_W-1:0]     in_status;
  logic [RN_W-1:0]       in_read_num;
  logic [ADDR_W-1:0]     in_x;
  logic [63:0]           in_primary;
  logic [12*IDX_W-1:0]   in_ok;
  logic [4*IDX_W-1:0]    in_p;
  logic [ADDR_W-1:0]     in_min_intv;
  logic [ADDR_W-1:0]     in_bi;
  logic [ADDR_W-1:0]     in_bj;
  logic                  in_iter_bnd;
  logic [ADDR_W-1:0]     in_curr_wr;
  logic [ADDR_W-1:0]     in_curr_rd;
  logic [ADDR_W-1:0]     in_mem_wr;
  logic [ADDR_W-1:0]     in_new_size;
  logic [ADDR_W-1:0]     in_last_size;
  logic [ADDR_W-1:0]     in_fwd_size;
  logic [31:0]           in_last_mem_info;
  logic [IDX_W-1:0]      in_last_x2;
  logic [7:0]            in_c;

  logic                  out_valid;
  logic                  out_ready;
  logic [STAT_W-1:0]     out_status;
  logic [RN_W-1:0]       out_read_num;
  logic [ADDR_W-1:0]     out_x;
  logic [63:0]           out_primary;
  logic [ADDR_W-1:0]     out_min_intv;
  logic [ADDR_W-1:0]     out_bi;
  logic [ADDR_W-1:0]     out_bj;
  logic                  out_iter_bnd;
  logic [ADDR_W-1:0]     out_curr_wr;
  logic [ADDR_W-1:0]     out_curr_rd;
  logic [ADDR_W-1:0]     out_mem_wr;
  logic [ADDR_W-1:0]     out_new_size;
  logic [ADDR_W-1:0]     out_last_size;
  logic [ADDR_W-1:0]     out_fwd_size;
  logic [31:0]           out_last_mem_info;
  logic [IDX_W-1:0]      out_last_x2;
  logic [7:0]            out_c;

  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [4*IDX_W-1:0]    mem_data;
  logic                  curr_we;
  logic [ADDR_W-1:0]     curr_addr;
  logic [4*IDX_W-1:0]    curr_data;
  logic                  ovf;

  modport master (
    output in_valid, in_status, in_read_num, in_x, in_primary, in_ok, in_p,
           in_min_intv, in_bi, in_bj, in_iter_bnd, in_curr_wr, in_curr_rd,
           in_mem_wr, in_new_size, in_last_size, in_fwd_size,
           in_last_mem_info, in_last_x2, in_c, out_ready,
    input  in_ready, out_valid, out_status, out_read_num, out_x, out_primary,
           out_min_intv, out_bi, out_bj, out_iter_bnd, out_curr_wr,
           out_curr_rd, out_mem_wr, out_new_size, out_last_size, out_fwd_size,
           out_last_mem_info, out_last_x2, out_c,
           mem_we, mem_addr, mem_data, curr_we, curr_addr, curr_data, ovf
  );

  modport slave (
    input  in_valid, in_status, in_read_num, in_x, in_primary, in_ok, in_p,
           in_min_intv, in_bi, in_bj, in_iter_bnd, in_curr_wr, in_curr_rd,
           in_mem_wr, in_new_size, in_last_size, in_fwd_size,
           in_last_mem_info, in_last_x2, in_c, out_ready,
    output in_ready, out_valid, out_status, out_read_num, out_x, out_primary,
           out_min_intv, out_bi, out_bj, out_iter_bnd, out_curr_wr,
           out_curr_rd, out_mem_wr, out_new_size, out_last_size, out_fwd_size,
           out_last_mem_info, out_last_x2, out_c,
           mem_we, mem_addr, mem_data, curr_we, curr_addr, curr_data, ovf
  );

endinterface

// File: rtl/bck_skid_reg.sv
// Two-entry output register: a main entry presented downstream plus one skid
// entry that absorbs a transfer arriving while downstream stalls.
module bck_skid_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  output logic         ready,
  input  logic [W-1:0] data,
  output logic         valid,
  input  logic         out_ready,
  output logic [W-1:0] q
);
  import bck_pkg::*;

  skid_state_e  state;
  logic [W-1:0] main_q;
  logic [W-1:0] skid_q;

  // NOTE: the payload registers are reset as well, so the downstream bundle
  // reads all-zero after reset and no stale entry survives a mid-run reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            main_q <= data;
            state  <= FULL;
          end
        end
        FULL: begin
          if (out_ready) begin
            if (push) main_q <= data;
            else      state  <= EMPTY;
          end else if (push) begin
            skid_q <= data;
            state  <= SKID;
          end
        end
        SKID: begin
          if (out_ready) begin
            main_q <= skid_q;
            state  <= FULL;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign ready = (state != SKID);
  assign valid = (state != EMPTY);
  assign q     = main_q;

endmodule

// File: rtl/bck_ext_stage_p.sv
// Backward-extension step: initialises or advances the per-read loop state and
// emits mem/curr store writes, one cycle after each accepted bundle.
module bck_ext_stage_p #(
  parameter int IDX_W  = 64,
  parameter int ADDR_W = 7,
  parameter int DEPTH  = 128,
  parameter int RN_W   = 8,
  parameter int STAT_W = bck_pkg::STAT_W
) (
  input logic              clk,
  input logic              rst,
  bck_ext_stage_p_if.slave bus
);
  import bck_pkg::*;

  localparam int HI_W  = IDX_W - 32;
  localparam int PAY_W = STAT_W + RN_W + 10*ADDR_W + 1 + 64 + 32 + IDX_W + 8;

  logic              ready_int, transfer, is_ini, is_run, push;
  logic [IDX_W-1:0]  p_x0, p_x1, p_x2, p_info;
  logic [IDX_W-1:0]  sel_x0, sel_x1, sel_x2;
  logic [ADDR_W-1:0] new_i;
  logic              ifc, cond_mem, cond_curr, mem_full, curr_full;
  logic              mem_go, curr_go, ovf_set;

  logic [ADDR_W-1:0] n_bi, n_bj, n_curr_wr, n_curr_rd, n_mem_wr, n_new_size, n_last_size;
  logic              n_iter_bnd;
  logic [31:0]       n_last_mem_info;
  logic [IDX_W-1:0]  n_last_x2;
  logic [7:0]        n_c;
  logic [PAY_W-1:0]  pay_d, pay_q;

  logic                 mem_we_q, curr_we_q, ovf_q;
  logic [ADDR_W-1:0]    mem_addr_q, curr_addr_q;
  logic [4*IDX_W-1:0]   mem_data_q, curr_data_q;

  assign transfer = bus.in_valid & ready_int;
  assign is_ini   = (bus.in_status == STAT_W'(BCK_INI));
  assign is_run   = (bus.in_status == STAT_W'(BCK_RUN));
  assign push     = transfer & (is_ini | is_run);

  // in_p packs x0 in the lowest word; in_ok packs ok[c].x0 at word 3*c.
  assign p_x0   = bus.in_p[0*IDX_W +: IDX_W];
  assign p_x1   = bus.in_p[1*IDX_W +: IDX_W];
  assign p_x2   = bus.in_p[2*IDX_W +: IDX_W];
  assign p_info = bus.in_p[3*IDX_W +: IDX_W];

  // NOTE: every variable gets a default before any conditional assignment,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    sel_x0 = '0;
    sel_x1 = '0;
    sel_x2 = '0;
    for (int k = 0; k < 4; k++) begin
      if (bus.in_c[1:0] == 2'(k)) begin
        sel_x0 = bus.in_ok[(3*k+0)*IDX_W +: IDX_W];
        sel_x1 = bus.in_ok[(3*k+1)*IDX_W +: IDX_W];
        sel_x2 = bus.in_ok[(3*k+2)*IDX_W +: IDX_W];
      end
    end
  end

  assign new_i     = bus.in_iter_bnd ? '0 : bus.in_bi + ADDR_W'(1);
  assign ifc       = (bus.in_c >= 8'd4) | bus.in_iter_bnd |
                     (sel_x2 < IDX_W'(bus.in_min_intv));
  assign cond_mem  = ifc & (bus.in_new_size == '0) &
                     ((bus.in_mem_wr == '0) | (32'(new_i) < bus.in_last_mem_info));
  assign cond_curr = ~ifc & ((bus.in_new_size == '0) | (sel_x2 != bus.in_last_x2));
  assign mem_full  = (bus.in_mem_wr == ADDR_W'(DEPTH - 1));
  assign curr_full = (bus.in_curr_wr == '0);
  assign mem_go    = transfer & is_run & cond_mem & ~mem_full;
  assign curr_go   = transfer & is_run & cond_curr & ~curr_full;
  assign ovf_set   = transfer & is_run & ((cond_mem & mem_full) | (cond_curr & curr_full));

  always_comb begin
    n_bi            = bus.in_bi;
    n_bj            = bus.in_bj;
    n_iter_bnd      = bus.in_iter_bnd;
    n_c             = bus.in_c;
    n_curr_wr       = bus.in_curr_wr;
    n_curr_rd       = bus.in_curr_rd;
    n_mem_wr        = bus.in_mem_wr;
    n_new_size      = bus.in_new_size;
    n_last_size     = bus.in_last_size;
    n_last_mem_info = bus.in_last_mem_info;
    n_last_x2       = bus.in_last_x2;
    if (is_ini) begin
      n_curr_wr       = bus.in_fwd_size - ADDR_W'(1);
      n_curr_rd       = bus.in_fwd_size - ADDR_W'(1);
      n_bj            = '0;
      n_last_size     = bus.in_fwd_size;
      n_new_size      = '0;
      n_mem_wr        = '0;
      n_last_x2       = '0;
      n_last_mem_info = '0;
      if (bus.in_x == '0) begin
        n_bi       = '0;
        n_iter_bnd = 1'b1;
        n_c        = '0;
      end else begin
        n_bi       = bus.in_x - ADDR_W'(1);
        n_iter_bnd = 1'b0;
        n_c        = 8'(bus.in_x - ADDR_W'(1));
      end
    end else if (is_run) begin
      n_c       = 8'(bus.in_bi);
      n_curr_rd = (bus.in_bj == bus.in_last_size - ADDR_W'(1)) ?
                  bus.in_fwd_size - ADDR_W'(1) : bus.in_curr_rd - ADDR_W'(1);
      // A blocked write leaves its pointer and bookkeeping untouched.
      if (cond_mem && !mem_full) begin
        n_mem_wr        = bus.in_mem_wr + ADDR_W'(1);
        n_last_mem_info = 32'(new_i);
      end
      if (cond_curr && !curr_full) begin
        n_curr_wr  = bus.in_curr_wr - ADDR_W'(1);
        n_new_size = bus.in_new_size + ADDR_W'(1);
        n_last_x2  = sel_x2;
      end
    end
  end

  assign pay_d = {bus.in_status, bus.in_read_num, bus.in_x, bus.in_primary,
                  bus.in_min_intv, n_bi, n_bj, n_iter_bnd, n_curr_wr, n_curr_rd,
                  n_mem_wr, n_new_size, n_last_size, bus.in_fwd_size,
                  n_last_mem_info, n_last_x2, n_c};

  bck_skid_reg #(.W(PAY_W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .ready     (ready_int),
    .data      (pay_d),
    .valid     (bus.out_valid),
    .out_ready (bus.out_ready),
    .q         (pay_q)
  );

  assign bus.in_ready = ready_int;
  assign {bus.out_status, bus.out_read_num, bus.out_x, bus.out_primary,
          bus.out_min_intv, bus.out_bi, bus.out_bj, bus.out_iter_bnd,
          bus.out_curr_wr, bus.out_curr_rd, bus.out_mem_wr, bus.out_new_size,
          bus.out_last_size, bus.out_fwd_size, bus.out_last_mem_info,
          bus.out_last_x2, bus.out_c} = pay_q;

  // Store writes track the transfer, not the downstream handshake.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      curr_we_q   <= 1'b0;
      curr_addr_q <= '0;
      curr_data_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      mem_we_q  <= mem_go;
      curr_we_q <= curr_go;
      if (mem_go) begin
        mem_addr_q <= bus.in_mem_wr;
        mem_data_q <= {p_x0, p_x1, p_x2, HI_W'(new_i), p_info[31:0]};
      end
      if (curr_go) begin
        curr_addr_q <= bus.in_curr_wr;
        curr_data_q <= {sel_x0, sel_x1, sel_x2, p_info};
      end
      if (transfer && is_ini) ovf_q <= 1'b0;
      else if (ovf_set)       ovf_q <= 1'b1;
    end
  end

  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_data  = mem_data_q;
  assign bus.curr_we   = curr_we_q;
  assign bus.curr_addr = curr_addr_q;
  assign bus.curr_data = curr_data_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_bck_ext_stage_p.sv
// Directed bench for bck_ext_stage_p: a vector table of init/run bundles with
// hand-computed results, then backpressure and mid-skid reset sequences.
module tb_bck_ext_stage_p;
  import bck_pkg::*;

  localparam int IDX_W  = 64;
  localparam int ADDR_W = 7;
  localparam int DEPTH  = 128;
  localparam int RN_W   = 8;
  localparam int NV     = 14;

  localparam logic [63:0] P_X0    = 64'h0000_0000_0000_0011;
  localparam logic [63:0] P_X1    = 64'h0000_0000_0000_0022;
  localparam logic [63:0] P_X2    = 64'h0000_0000_0000_0033;
  localparam logic [63:0] P_INFO  = 64'hAAAA_BBBB_CCCC_DDDD;
  localparam logic [63:0] PRIMARY = 64'h1234_5678_9ABC_DEF0;

  typedef struct packed {
    logic [5:0]  st;
    logic [6:0]  x, bi, bj;
    logic        it;
    logic [7:0]  c;
    logic [6:0]  mi, cw, cr, mw, ns, ls, fs;
    logic [31:0] lmi;
    logic [63:0] lx2, sx2;
    logic        e_valid;
    logic [6:0]  e_bi, e_bj;
    logic        e_it;
    logic [7:0]  e_c;
    logic [6:0]  e_cw, e_cr, e_mw, e_ns, e_ls;
    logic [31:0] e_lmi;
    logic [63:0] e_lx2;
    logic        e_mwe, e_cwe;
    logic [6:0]  e_addr;
    logic [31:0] e_hi;
    logic        e_ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_fail = 0;
  vec_t vecs [NV];

  always #5 clk = ~clk;

  bck_ext_stage_p_if #(.IDX_W(IDX_W), .ADDR_W(ADDR_W), .RN_W(RN_W), .STAT_W(STAT_W)) bus ();

  bck_ext_stage_p #(
    .IDX_W(IDX_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RN_W(RN_W), .STAT_W(STAT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t vin(input logic [5:0] st, input int x, bi, bj, it, c, mi,
                               cw, cr, mw, ns, ls, fs, lmi, lx2, sx2);
    vec_t v;
    v     = '0;
    v.st  = st;     v.x   = 7'(x);   v.bi  = 7'(bi);  v.bj = 7'(bj);
    v.it  = 1'(it); v.c   = 8'(c);   v.mi  = 7'(mi);  v.cw = 7'(cw);
    v.cr  = 7'(cr); v.mw  = 7'(mw);  v.ns  = 7'(ns);  v.ls = 7'(ls);
    v.fs  = 7'(fs); v.lmi = 32'(lmi); v.lx2 = 64'(lx2); v.sx2 = 64'(sx2);
    return v;
  endfunction

  function automatic vec_t vexp(input vec_t v, input int valid, bi, bj, it, c, cw, cr,
                                mw, ns, ls, lmi, lx2, mwe, cwe, addr, hi, ovf);
    vec_t r;
    r         = v;
    r.e_valid = 1'(valid); r.e_bi  = 7'(bi);  r.e_bj  = 7'(bj);   r.e_it  = 1'(it);
    r.e_c     = 8'(c);     r.e_cw  = 7'(cw);  r.e_cr  = 7'(cr);   r.e_mw  = 7'(mw);
    r.e_ns    = 7'(ns);    r.e_ls  = 7'(ls);  r.e_lmi = 32'(lmi); r.e_lx2 = 64'(lx2);
    r.e_mwe   = 1'(mwe);   r.e_cwe = 1'(cwe); r.e_addr = 7'(addr); r.e_hi = 32'(hi);
    r.e_ovf   = 1'(ovf);
    return r;
  endfunction

  task automatic drive(input vec_t v, input logic [7:0] rn);
    logic [12*IDX_W-1:0] ok;
    ok = '0;
    for (int k = 0; k < 4; k++) begin
      ok[(3*k+0)*IDX_W +: IDX_W] = 64'(100 + k);
      ok[(3*k+1)*IDX_W +: IDX_W] = 64'(200 + k);
      ok[(3*k+2)*IDX_W +: IDX_W] = (2'(k) == v.c[1:0]) ? v.sx2 : 64'd999;
    end
    bus.in_valid         = 1'b1;
    bus.in_status        = v.st;
    bus.in_read_num      = rn;
    bus.in_x             = v.x;
    bus.in_primary       = PRIMARY;
    bus.in_ok            = ok;
    bus.in_p             = {P_INFO, P_X2, P_X1, P_X0};
    bus.in_min_intv      = v.mi;
    bus.in_bi            = v.bi;
    bus.in_bj            = v.bj;
    bus.in_iter_bnd      = v.it;
    bus.in_curr_wr       = v.cw;
    bus.in_curr_rd       = v.cr;
    bus.in_mem_wr        = v.mw;
    bus.in_new_size      = v.ns;
    bus.in_last_size     = v.ls;
    bus.in_fwd_size      = v.fs;
    bus.in_last_mem_info = v.lmi;
    bus.in_last_x2       = v.lx2;
    bus.in_c             = v.c;
  endtask

  task automatic check_vec(input int i, input vec_t v, input logic [7:0] rn);
    string t;
    logic [255:0] e_md, e_cd;
    t    = $sformatf("v%0d", i);
    e_md = {P_X0, P_X1, P_X2, v.e_hi, P_INFO[31:0]};
    e_cd = {64'(100 + int'(v.c[1:0])), 64'(200 + int'(v.c[1:0])), v.sx2, P_INFO};
    check({t, ".out_valid"}, bus.out_valid, v.e_valid);
    check({t, ".in_ready"},  bus.in_ready, 1'b1);
    check({t, ".mem_we"},    bus.mem_we, v.e_mwe);
    check({t, ".curr_we"},   bus.curr_we, v.e_cwe);
    check({t, ".ovf"},       bus.ovf, v.e_ovf);
    if (v.e_valid) begin
      check({t, ".status"},        bus.out_status, v.st);
      check({t, ".read_num"},      bus.out_read_num, rn);
      check({t, ".primary"},       bus.out_primary, PRIMARY);
      check({t, ".bi"},            bus.out_bi, v.e_bi);
      check({t, ".bj"},            bus.out_bj, v.e_bj);
      check({t, ".iter_bnd"},      bus.out_iter_bnd, v.e_it);
      check({t, ".c"},             bus.out_c, v.e_c);
      check({t, ".curr_wr"},       bus.out_curr_wr, v.e_cw);
      check({t, ".curr_rd"},       bus.out_curr_rd, v.e_cr);
      check({t, ".mem_wr"},        bus.out_mem_wr, v.e_mw);
      check({t, ".new_size"},      bus.out_new_size, v.e_ns);
      check({t, ".last_size"},     bus.out_last_size, v.e_ls);
      check({t, ".fwd_size"},      bus.out_fwd_size, v.fs);
      check({t, ".last_mem_info"}, bus.out_last_mem_info, v.e_lmi);
      check({t, ".last_x2"},       bus.out_last_x2, v.e_lx2);
    end
    if (v.e_mwe) begin
      check({t, ".mem_addr"}, bus.mem_addr, v.e_addr);
      check({t, ".mem_data"}, bus.mem_data, e_md);
    end
    if (v.e_cwe) begin
      check({t, ".curr_addr"}, bus.curr_addr, v.e_addr);
      check({t, ".curr_data"}, bus.curr_data, e_cd);
    end
  endtask

  initial begin
    //                  st       x  bi bj it c  mi cw  cr mw  ns ls fs lmi lx2 sx2
    vecs[0]  = vin(BCK_INI,  0, 5, 3, 0, 9, 3, 9,  9, 3,  2, 4, 5, 7,  55, 0);
    vecs[1]  = vin(BCK_INI, 10, 0, 0, 0, 0, 3, 0,  0, 0,  0, 0, 8, 0,  0,  0);
    vecs[2]  = vin(BCK_RUN,  0, 3, 0, 0, 2, 3, 4,  4, 0,  0, 5, 5, 0,  0,  10);
    vecs[3]  = vin(BCK_RUN,  0, 6, 4, 0, 5, 3, 6,  2, 0,  0, 5, 9, 0,  0,  20);
    vecs[4]  = vin(BCK_RUN,  0, 9, 1, 1, 1, 3, 6,  5, 3,  0, 5, 9, 5,  0,  50);
    vecs[5]  = vin(BCK_RUN,  0, 4, 0, 0, 0, 3, 6,  5, 2,  0, 5, 9, 3,  0,  2);
    vecs[6]  = vin(BCK_RUN,  0, 2, 0, 0, 3, 3, 10, 5, 2,  2, 5, 9, 3,  40, 40);
    vecs[7]  = vin(BCK_RUN,  0, 2, 0, 0, 3, 3, 10, 5, 2,  2, 5, 9, 3,  40, 41);
    vecs[8]  = vin(BCK_RUN,  0, 2, 0, 0, 7, 3, 10, 5, 0,  1, 5, 9, 0,  0,  9);
    vecs[9]  = vin(BCK_RUN,  0, 1, 0, 0, 4, 3, 10, 5, 127, 0, 5, 9, 9, 0,  9);
    vecs[10] = vin(BUBBLE,   0, 0, 0, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0,  0,  0);
    vecs[11] = vin(BCK_RUN,  0, 1, 0, 0, 2, 3, 0,  5, 0,  0, 5, 9, 0,  0,  10);
    vecs[12] = vin(BCK_INI,  1, 5, 5, 1, 0, 3, 9,  9, 9,  9, 9, 3, 4,  4,  0);
    vecs[13] = vin(BCK_RUN,  0, 0, 1, 0, 2, 3, 2,  0, 0,  1, 5, 3, 0,  10, 10);
    //                       vld bi bj it c  cw  cr   mw   ns ls lmi lx2 mwe cwe adr hi ovf
    vecs[0]  = vexp(vecs[0],  1, 0, 0, 1, 0, 4,  4,   0,   0, 5, 0,  0,  0, 0, 0,  0, 0);
    vecs[1]  = vexp(vecs[1],  1, 9, 0, 0, 9, 7,  7,   0,   0, 8, 0,  0,  0, 0, 0,  0, 0);
    vecs[2]  = vexp(vecs[2],  1, 3, 0, 0, 3, 3,  3,   0,   1, 5, 0,  10, 0, 1, 4,  0, 0);
    vecs[3]  = vexp(vecs[3],  1, 6, 4, 0, 6, 6,  8,   1,   0, 5, 7,  0,  1, 0, 0,  7, 0);
    vecs[4]  = vexp(vecs[4],  1, 9, 1, 1, 9, 6,  4,   4,   0, 5, 0,  0,  1, 0, 3,  0, 0);
    vecs[5]  = vexp(vecs[5],  1, 4, 0, 0, 4, 6,  4,   2,   0, 5, 3,  0,  0, 0, 0,  0, 0);
    vecs[6]  = vexp(vecs[6],  1, 2, 0, 0, 2, 10, 4,   2,   2, 5, 3,  40, 0, 0, 0,  0, 0);
    vecs[7]  = vexp(vecs[7],  1, 2, 0, 0, 2, 9,  4,   2,   3, 5, 3,  41, 0, 1, 10, 0, 0);
    vecs[8]  = vexp(vecs[8],  1, 2, 0, 0, 2, 10, 4,   0,   1, 5, 0,  0,  0, 0, 0,  0, 0);
    vecs[9]  = vexp(vecs[9],  1, 1, 0, 0, 1, 10, 4,   127, 0, 5, 9,  0,  0, 0, 0,  0, 1);
    vecs[10] = vexp(vecs[10], 0, 0, 0, 0, 0, 0,  0,   0,   0, 0, 0,  0,  0, 0, 0,  0, 1);
    vecs[11] = vexp(vecs[11], 1, 1, 0, 0, 1, 0,  4,   0,   0, 5, 0,  0,  0, 0, 0,  0, 1);
    vecs[12] = vexp(vecs[12], 1, 0, 0, 0, 0, 2,  2,   0,   0, 3, 0,  0,  0, 0, 0,  0, 0);
    vecs[13] = vexp(vecs[13], 1, 0, 1, 0, 0, 2,  127, 0,   1, 5, 0,  10, 0, 0, 0,  0, 0);

    drive('0, 8'd0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    rst           = 1'b0;
    repeat (3) @(negedge clk);
    check("reset.out_valid", bus.out_valid, 1'b0);
    check("reset.in_ready",  bus.in_ready, 1'b1);
    check("reset.status",    bus.out_status, BUBBLE);
    check("reset.curr_rd",   bus.out_curr_rd, 7'd0);
    check("reset.mem_we",    bus.mem_we, 1'b0);
    check("reset.curr_we",   bus.curr_we, 1'b0);
    check("reset.ovf",       bus.ovf, 1'b0);
    rst = 1'b1;
    @(negedge clk);

    // Back-to-back transfers with downstream always ready.
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i], 8'(i + 1));
      @(negedge clk);
      bus.in_valid = 1'b0;
      check_vec(i, vecs[i], 8'(i + 1));
    end

    // Downstream stalls for three cycles while two bundles arrive.
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive(vin(BCK_INI, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 5, 0, 0, 0), 8'hA1);
    @(negedge clk);
    check("bp.ready_after_1st", bus.in_ready, 1'b1);
    check("bp.first_out",       bus.out_read_num, 8'hA1);
    drive(vin(BCK_INI, 3, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 6, 0, 0, 0), 8'hB2);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("bp.ready_after_2nd", bus.in_ready, 1'b0);
    check("bp.hold_valid",      bus.out_valid, 1'b1);
    check("bp.hold1",           bus.out_read_num, 8'hA1);
    @(negedge clk);
    check("bp.hold2",           bus.out_read_num, 8'hA1);
    check("bp.hold2_bi",        bus.out_bi, 7'd0);
    check("bp.still_blocked",   bus.in_ready, 1'b0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp.second_valid",    bus.out_valid, 1'b1);
    check("bp.second_out",      bus.out_read_num, 8'hB2);
    check("bp.second_bi",       bus.out_bi, 7'd2);
    check("bp.second_curr_wr",  bus.out_curr_wr, 7'd5);
    check("bp.ready_again",     bus.in_ready, 1'b1);
    @(negedge clk);
    check("bp.drained",         bus.out_valid, 1'b0);

    // Reset while an entry sits in the skid register with ovf set.
    bus.out_ready = 1'b0;
    drive(vecs[9], 8'hC1);
    @(negedge clk);
    drive(vecs[2], 8'hC2);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("rs.skid_full",   bus.in_ready, 1'b0);
    check("rs.ovf_before",  bus.ovf, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    check("rs.out_valid",   bus.out_valid, 1'b0);
    check("rs.in_ready",    bus.in_ready, 1'b1);
    check("rs.read_num",    bus.out_read_num, 8'h00);
    check("rs.status",      bus.out_status, BUBBLE);
    check("rs.curr_wr",     bus.out_curr_wr, 7'd0);
    check("rs.last_x2",     bus.out_last_x2, 64'd0);
    check("rs.curr_addr",   bus.curr_addr, 7'd0);
    check("rs.mem_we",      bus.mem_we, 1'b0);
    check("rs.curr_we",     bus.curr_we, 1'b0);
    check("rs.ovf",         bus.ovf, 1'b0);
    rst           = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("rs.no_stale",    bus.out_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/bck_ext_stage_p.md
BCK_EXT_STAGE_P -- requirements
Module: bck_ext_stage_p

Interface
REQ-001 Parameters (name, default, meaning), one per line:
 IDX_W, 64, SA interval field width.
 ADDR_W, 7, address/size/index width.
 DEPTH, 128, mem/curr buffer entries (≤2^ADDR_W).
 RN_W, 8, read-number width.
 STAT_W, 6, status code width.
REQ-002 Ports (name, direction, width, meaning), one per line:
 clk, in, 1, clock.
 rst, in, 1, reset: synchronous, active-low.
 in_valid/in_ready, in/out, 1, upstream handshake.
 in_status, in, STAT_W, BUBBLE/BCK_INI/BCK_RUN.
 in_read_num, in, RN_W, read id.
 in_x, in, ADDR_W, backward start position.
 in_primary, in, 64, primary index.
 in_ok, in, 12*IDX_W, ok[c].{x0,x1,x2}, c=0..3, c-major.
 in_p, in, 4*IDX_W, p.{x0,x1,x2,info}.
 in_min_intv, in_bi, in_bj, in, ADDR_W, min interval, loop indices.
 in_iter_bnd, in, 1, iteration boundary.
 in_curr_wr, in_curr_rd, in_mem_wr, in_new_size, in_last_size, in_fwd_size, in, ADDR_W, pointers/sizes.
 in_last_mem_info, in, 32; in_last_x2, in, IDX_W; in_c, in, 8.
 out_valid/out_ready, out/in, 1, downstream handshake.
 out_*, out, same widths, registered bundle of all in_* fields (in_ok/in_p excluded).
 mem_we, mem_addr, mem_data, out, 1/ADDR_W/4*IDX_W, mem store port.
 curr_we, curr_addr, curr_data, out, 1/ADDR_W/4*IDX_W, curr store port.
 ovf, out, 1, sticky pointer overflow flag.

Function
REQ-003 Transfer = in_valid&in_ready; output bundle and store writes appear exactly 1 cycle after transfer.
REQ-004 in_ready=0 only when skid entry occupied; states EMPTY→(transfer)FULL; FULL&!out_ready&transfer→SKID; SKID&out_ready→FULL; FULL&out_ready&!transfer→EMPTY.
REQ-005 out_valid=1 in FULL/SKID; bundle held stable while out_valid&!out_ready.
REQ-006 BUBBLE/other status: consumed, no bundle, no writes.
REQ-007 BCK_INI: curr_rd=curr_wr=fwd_size-1, bj=0, last_size=fwd_size, new_size=mem_wr=0, last_x2=last_mem_info=0; in_x==0 → bi=0, iter_bnd=1, c=0; else bi=in_x-1, iter_bnd=0, c=in_x-1; ovf cleared.
REQ-008 BCK_RUN: new_i=iter_bnd?0:bi+1; amb=(c≥4); sel=ok[c[1:0]]; ifc=amb|iter_bnd|(sel.x2<min_intv).
REQ-009 cond_mem=ifc&(new_size==0)&(mem_wr==0|new_i<last_mem_info): mem_we, mem_addr=mem_wr, mem_data={p.x0,p.x1,p.x2,{new_i zero-extended,p.info[31:0]}}, mem_wr+1, last_mem_info=new_i.
REQ-010 cond_curr=!ifc&(new_size==0|sel.x2!=last_x2): curr_we, curr_addr=curr_wr, curr_data={sel.x0,sel.x1,sel.x2,p.info}, curr_wr-1, new_size+1, last_x2=sel.x2.
REQ-011 cond_mem and cond_curr mutually exclusive; neither → pointers unchanged.
REQ-012 curr_rd = (bj==last_size-1) ? fwd_size-1 : curr_rd-1 mod 2^ADDR_W; out_c=bi; other fields pass through.
REQ-013 mem_wr==DEPTH-1 with cond_mem, or curr_wr==0 with cond_curr: write suppressed, pointer held, ovf=1 until next BCK_INI.
REQ-014 mem_we/curr_we single-cycle pulses, independent of out_ready.

Reset
REQ-015 rst=0: state EMPTY, in_ready=1, out_valid=0, all out_* 0, out_status=BUBBLE, mem_we=curr_we=0, ovf=0; mid-operation reset discards held/skid data.

Structure
REQ-016 Status codes BUBBLE/BCK_INI/BCK_RUN and STAT_W in shared package bck_pkg.
REQ-017 Handshake/skid as sub-module bck_skid_reg (parametrised payload width); decision logic inline.

Verification
REQ-018 INI in_x=0, fwd_size=5 → out bi=0, iter_bnd=1, curr_rd=curr_wr=4, no writes.
REQ-019 RUN c=2, ok[2].x2=10, min_intv=3, new_size=0, curr_wr=4 → curr_we, curr_addr=4, out curr_wr=3, new_size=1.
REQ-020 RUN c=5, new_size=0, mem_wr=0, bi=6 → mem_we, addr=0, info upper=7, out mem_wr=1.
REQ-021 out_ready=0 for 3 cycles, 2 back-to-back transfers → in_ready=0 after 2nd, both bundles delivered in order, none lost.
REQ-022 mem_wr=DEPTH-1 with cond_mem → mem_we=0, ovf=1; next BCK_INI → ovf=0.
REQ-023 rst=0 while SKID → next cycle out_valid=0, in_ready=1, outputs zero.
